// File: rtl/pgr_rst_seq.sv
// Multi-channel reset sequencer: synchronises and filters an external reset and a PLL
// lock, holds for a programmable time, then releases CH_NUM active-low resets in
// ascending index order, STAGE_LEN cycles apart. Any loss of reset/lock or a soft
// reset request past the filter stage aborts the sequence and bumps a saturating counter.
module pgr_rst_seq #(
    parameter int unsigned CH_NUM      = 4,
    parameter int unsigned FILT_WIDTH  = 4,
    parameter int unsigned HOLD_WIDTH  = 18,
    parameter int unsigned STAGE_LEN   = 256,
    parameter bit          SIM_SPEEDUP = 1'b0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              ext_rst_n,
    input  logic              lock_in,
    input  logic              soft_rst,
    output logic [CH_NUM-1:0] rst_n_out,
    output logic              seq_done,
    output logic [7:0]        abort_cnt
);

    localparam int unsigned FILT_LEN = 2 ** FILT_WIDTH;
    localparam int unsigned HOLD_LEN = SIM_SPEEDUP ? 8 : 2 ** HOLD_WIDTH;
    localparam int unsigned STG_LEN  = SIM_SPEEDUP ? 2 : STAGE_LEN;
    localparam int unsigned STG_W    = $clog2(STG_LEN + 1);

    localparam logic [FILT_WIDTH:0] FILT_MAX = (FILT_WIDTH + 1)'(FILT_LEN - 1);
    localparam logic [HOLD_WIDTH:0] HOLD_MAX = (HOLD_WIDTH + 1)'(HOLD_LEN - 1);
    localparam logic [STG_W-1:0]    STG_MAX  = STG_W'(STG_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFilter,
        StHold,
        StRelease,
        StDone
    } state_t;

    state_t              state_q, state_d;
    logic                ext_m, ext_s, lock_m, lock_s;
    logic [FILT_WIDTH:0] filt_q, filt_d;
    logic [HOLD_WIDTH:0] hold_q, hold_d;
    logic [STG_W-1:0]    stg_q, stg_d;
    logic [CH_NUM-1:0]   rst_q, rst_d, rel_next;
    logic                done_q, done_d;
    logic [7:0]          abort_q, abort_d;
    logic                ok;
    logic                abort;

    // Two-flop synchronisers for the asynchronous pins.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ext_m  <= 1'b0;
            ext_s  <= 1'b0;
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            ext_m  <= ext_rst_n;
            ext_s  <= ext_m;
            lock_m <= lock_in;
            lock_s <= lock_m;
        end
    end

    assign ok = ext_s & lock_s & ~soft_rst;

    // Channels only ever fill from index 0 upwards, so the next release pattern is a shift-in of one.
    assign rel_next = (rst_q << 1) | CH_NUM'(1);

    // Loss of ok is only an abort once the filter has passed.
    assign abort = ~ok & ((state_q == StHold) | (state_q == StRelease) | (state_q == StDone));

    // State, counters and output registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= StIdle;
            filt_q  <= '0;
            hold_q  <= '0;
            stg_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            abort_q <= '0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            hold_q  <= hold_d;
            stg_q   <= stg_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    // Next-state logic; abort takes priority over any release in the same cycle.
    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        hold_d  = hold_q;
        stg_d   = stg_q;
        rst_d   = rst_q;
        done_d  = done_q;
        abort_d = abort_q;
        if (abort) begin
            state_d = StIdle;
            filt_d  = '0;
            hold_d  = '0;
            stg_d   = '0;
            rst_d   = '0;
            done_d  = 1'b0;
            if (abort_q != 8'hFF) begin
                abort_d = abort_q + 8'd1;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ok) begin
                        state_d = StFilter;
                        filt_d  = '0;
                    end
                end
                StFilter: begin
                    if (!ok) begin
                        state_d = StIdle;
                        filt_d  = '0;
                    end else if (filt_q == FILT_MAX) begin
                        state_d = StHold;
                        filt_d  = '0;
                        hold_d  = '0;
                    end else begin
                        filt_d = filt_q + (FILT_WIDTH + 1)'(1);
                    end
                end
                StHold: begin
                    if (hold_q == HOLD_MAX) begin
                        hold_d  = '0;
                        stg_d   = '0;
                        rst_d   = rel_next;
                        state_d = rel_next[CH_NUM-1] ? StDone : StRelease;
                        done_d  = rel_next[CH_NUM-1];
                    end else begin
                        hold_d = hold_q + (HOLD_WIDTH + 1)'(1);
                    end
                end
                StRelease: begin
                    if (stg_q == STG_MAX) begin
                        stg_d   = '0;
                        rst_d   = rel_next;
                        state_d = rel_next[CH_NUM-1] ? StDone : StRelease;
                        done_d  = rel_next[CH_NUM-1];
                    end else begin
                        stg_d = stg_q + STG_W'(1);
                    end
                end
                StDone: begin
                    filt_d = '0;
                    hold_d = '0;
                    stg_d  = '0;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign rst_n_out = rst_q;
    assign seq_done  = done_q;
    assign abort_cnt = abort_q;

endmodule
